sat_ctrl_gen: RTL and testbench
===============================

Name: sat_ctrl_gen

Overview:
Byte-serial saturating adder/subtractor and the producer side of the saturation control interface (raw byte + sat_enable/sat_sign/sat_last).
- Accepts two multi-byte two's-complement operands LSB byte first and computes the sum or difference with a carry chain.
- Buffers the result bytes, decides signed overflow once the MSB byte arrives, then replays the bytes LSB first with per-word saturation flags.
- Downstream, the byte saturation unit clamps each byte: FF/00 for lower bytes, 7F/80 for the MSB byte.

Parameters:
MAX_BYTES, 4, maximum bytes per word (buffer depth); legal range 1..16.
CNT_W, $clog2(MAX_BYTES)+1, index/length counter width (derived; do not override).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operand byte pair valid.
in_ready  output  1  block can accept an operand byte pair.
in_a  input  8  operand A byte.
in_b  input  8  operand B byte.
in_last  input  1  this pair is the MSB byte of the word.
in_sub  input  1  1 = A−B, 0 = A+B; sampled on the first byte of a word only.
out_valid  output  1  result byte valid.
out_ready  input  1  downstream accepts result byte.
out_a  output  8  raw (unsaturated) result byte; feeds the saturation unit's a.
sat_enable  output  1  word overflowed; constant across all bytes of the word.
sat_sign  output  1  0 = positive overflow, 1 = negative overflow; constant per word.
sat_last  output  1  this byte is the MSB byte of the word.
err_overlength  output  1  one-cycle pulse: word truncated at MAX_BYTES.

Behaviour:
- Handshakes: a transfer occurs on a rising clk edge where valid && ready.
- Reset (rst_n low, asynchronous):
  - State = COLLECT; all counters, buffer, carry and flags cleared.
  - out_valid, out_a, sat_enable, sat_sign, sat_last and err_overlength are all 0.
  - in_ready is forced 0 while rst_n is low and is 1 in the first cycle after release.
- COLLECT state:
  - in_ready = 1, out_valid = 0.
  - On each accepted pair at index wr (0-based): beff = in_sub_eff ? ~in_b : in_b; {c_out, s} = in_a + beff + c_in.
  - c_in = in_sub on byte 0; otherwise c_in is the stored c_out of the previous byte.
  - s is written to buf[wr], then wr increments.
  - in_sub_eff equals in_sub on byte 0 and the latched value on later bytes; in_sub changes mid-word are ignored.
  - The MSB byte is accepted when in_last = 1, or when wr == MAX_BYTES-1 regardless of in_last.
- On accepting the MSB byte:
  - ovf = (in_a[7] == beff[7]) && (s[7] != in_a[7]); sat_sign_reg = in_a[7]; len = wr+1.
  - Next state = EMIT, with rd = 0.
  - If the byte was forced (in_last = 0 at wr == MAX_BYTES-1), err_overlength = 1 for exactly one cycle. The next pair offered starts a new word.
- EMIT state:
  - in_ready = 0, out_valid = 1, out_a = buf[rd], sat_enable = ovf, sat_sign = sat_sign_reg, sat_last = (rd == len-1).
  - When out_valid = 0, sat_enable/sat_sign/sat_last/out_a are 0.
  - On out_ready, rd increments. On the transfer with sat_last = 1, the block returns to COLLECT and clears wr and carry.
  - If out_ready is low, all outputs hold stable.
- Latency:
  - The first result byte is valid in the cycle after the MSB byte is accepted.
  - With out_ready held at 1, a word of N bytes occupies N input cycles plus N output cycles.
  - No input/output overlap.
- Single-byte word (in_last on byte 0): behaves as a saturating 8-bit add/sub; sat_last = 1 on that byte.
- MAX_BYTES = 1: every byte is MSB; err_overlength pulses whenever in_last = 0.
- Reset asserted mid-word or mid-EMIT: the in-flight word is discarded immediately and no partial bytes are emitted after release.
- Outputs are driven from registers/buffer only; there is no combinational path from in_* to out_*.

Test Plan:
- No overflow: A=0x1234 (34,12), B=0x0101, sub=0, out_ready=1 -> out_a 35 then 13; sat_enable=0; sat_last 0 then 1; saturated word 0x1335.
- Positive overflow: A=0x7FFF, B=0x0001, add -> out_a 00,80; sat_enable=1, sat_sign=0; saturation unit yields FF,7F.
- Negative overflow, subtract: A=0x8000, B=0x0001, sub=1 -> out_a FF,7F; sat_enable=1, sat_sign=1; saturated 00,80.
- Single byte: A=0x80, B=0xFF, in_last=1 -> out_a 7F, sat_enable=1, sat_sign=1, sat_last=1; saturated 0x80.
- Backpressure:
  - Stimulus: A=0x0102, B=0x0000; out_ready low for 3 cycles on byte 0.
  - Required: out_a=02 and flags held stable, in_ready=0; after out_ready rises, 02 then 01 are emitted with no loss.
- Overlength and reset (MAX_BYTES=4):
  - Five pairs with in_last=0 -> 4th pair treated as MSB, err_overlength pulses once, 5th pair starts a new word.
  - Then assert rst_n low mid-EMIT -> out_valid drops immediately; in_ready=1 after release; no stale bytes are emitted.

Source files
------------

// File: rtl/sat_ctrl_gen.sv
// Byte-serial saturating add/sub: collects operand bytes LSB first, then replays
// the raw result bytes with per-word overflow flags for a downstream byte clamp.
module sat_ctrl_gen #(
    parameter int MAX_BYTES = 4,
    parameter int CNT_W     = $clog2(MAX_BYTES) + 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    input  logic       in_last,
    input  logic       in_sub,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_a,
    output logic       sat_enable,
    output logic       sat_sign,
    output logic       sat_last,
    output logic       err_overlength
);

    localparam int IDX_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_BYTES - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    typedef enum logic {COLLECT, EMIT} state_t;
    state_t state, state_d;

    logic [CNT_W-1:0] wr, rd, len;
    logic [7:0]       data_buf [2**IDX_W];
    logic             carry, sub_q, ovf, sign_q, err_q;

    logic       first, sub_eff, c_in, accept, msb, is_last;
    logic [7:0] beff;
    logic [8:0] sum;

    assign first   = (wr == '0);
    assign sub_eff = first ? in_sub : sub_q;
    assign c_in    = first ? in_sub : carry;
    assign beff    = sub_eff ? ~in_b : in_b;
    assign sum     = {1'b0, in_a} + {1'b0, beff} + {8'd0, c_in};
    assign accept  = in_valid && rst_n && (state == COLLECT);
    // A word never grows past the buffer: the last slot is taken as the MSB byte.
    assign msb     = in_last || (wr == LAST_IDX);
    assign is_last = (rd == len - ONE);
    assign err_overlength = err_q;

    always_comb begin
        state_d    = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_a      = 8'd0;
        sat_enable = 1'b0;
        sat_sign   = 1'b0;
        sat_last   = 1'b0;
        case (state)
            COLLECT: begin
                in_ready = rst_n;
                if (accept && msb)
                    state_d = EMIT;
            end
            EMIT: begin
                out_valid  = 1'b1;
                out_a      = data_buf[rd[IDX_W-1:0]];
                sat_enable = ovf;
                sat_sign   = sign_q;
                sat_last   = is_last;
                if (out_ready && is_last)
                    state_d = COLLECT;
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= COLLECT;
        else
            state <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr     <= '0;
            rd     <= '0;
            len    <= '0;
            carry  <= 1'b0;
            sub_q  <= 1'b0;
            ovf    <= 1'b0;
            sign_q <= 1'b0;
            err_q  <= 1'b0;
            for (int i = 0; i < 2**IDX_W; i++)
                data_buf[i] <= 8'd0;
        end else begin
            err_q <= 1'b0;
            if (accept) begin
                data_buf[wr[IDX_W-1:0]] <= sum[7:0];
                carry <= sum[8];
                if (first)
                    sub_q <= in_sub;
                if (msb) begin
                    // Signed overflow: operands agree in sign, result does not.
                    ovf    <= (in_a[7] == beff[7]) && (sum[7] != in_a[7]);
                    sign_q <= in_a[7];
                    len    <= wr + ONE;
                    rd     <= '0;
                    err_q  <= !in_last;
                end else begin
                    wr <= wr + ONE;
                end
            end
            if (state == EMIT && out_ready) begin
                if (is_last) begin
                    wr    <= '0;
                    rd    <= '0;
                    carry <= 1'b0;
                end else begin
                    rd <= rd + ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_sat_ctrl_gen.sv
// Directed bench for sat_ctrl_gen (MAX_BYTES = 4) with hand-computed results.
module tb_sat_ctrl_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready;
    logic [7:0] in_a, in_b;
    logic       in_last, in_sub;
    logic       out_valid, out_ready;
    logic [7:0] out_a;
    logic       sat_enable, sat_sign, sat_last, err_overlength;

    int checks = 0;
    int errors = 0;

    sat_ctrl_gen #(.MAX_BYTES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a),
        .sat_enable(sat_enable), .sat_sign(sat_sign), .sat_last(sat_last),
        .err_overlength(err_overlength)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered just after a rising edge; returns just after the edge that took the pair.
    task automatic send(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic last, input logic sub);
        in_a = a; in_b = b; in_last = last; in_sub = sub; in_valid = 1'b1;
        @(negedge clk);
        chk({tag, ".in_ready"}, in_ready, 1);
        chk({tag, ".no_out"}, out_valid, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [7:0] a, input logic en,
                              input logic sg, input logic last, input logic err);
        @(negedge clk);
        chk({tag, ".out_valid"}, out_valid, 1);
        chk({tag, ".out_a"}, out_a, a);
        chk({tag, ".sat_enable"}, sat_enable, en);
        chk({tag, ".sat_sign"}, sat_sign, sg);
        chk({tag, ".sat_last"}, sat_last, last);
        chk({tag, ".err"}, err_overlength, err);
        chk({tag, ".in_busy"}, in_ready, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_a = 8'd0; in_b = 8'd0;
        in_last = 1'b0; in_sub = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk); #1;
        chk("rst.in_ready", in_ready, 0);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.out_a", out_a, 0);
        chk("rst.flags", {sat_enable, sat_sign, sat_last, err_overlength}, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel.in_ready", in_ready, 1);

        // 0x1234 + 0x0101 = 0x1335, no overflow
        send("nov0", 8'h34, 8'h01, 0, 0);
        send("nov1", 8'h12, 8'h01, 1, 0);
        expect_out("nov.o0", 8'h35, 0, 0, 0, 0);
        expect_out("nov.o1", 8'h13, 0, 0, 1, 0);

        // 0x7FFF + 0x0001 -> positive overflow
        send("pov0", 8'hFF, 8'h01, 0, 0);
        send("pov1", 8'h7F, 8'h00, 1, 0);
        expect_out("pov.o0", 8'h00, 1, 0, 0, 0);
        expect_out("pov.o1", 8'h80, 1, 0, 1, 0);

        // 0x8000 - 0x0001 -> negative overflow; in_sub dropped mid-word is ignored
        send("nov_s0", 8'h00, 8'h01, 0, 1);
        send("nov_s1", 8'h80, 8'h00, 1, 0);
        expect_out("neg.o0", 8'hFF, 1, 1, 0, 0);
        expect_out("neg.o1", 8'h7F, 1, 1, 1, 0);

        // single byte 0x80 + 0xFF
        send("one", 8'h80, 8'hFF, 1, 0);
        expect_out("one.o0", 8'h7F, 1, 1, 1, 0);
        @(negedge clk);
        chk("one.idle", out_valid, 0);
        @(posedge clk); #1;

        // backpressure on byte 0 of 0x0102 + 0x0000
        send("bp0", 8'h02, 8'h00, 0, 0);
        out_ready = 1'b0;
        send("bp1", 8'h01, 8'h00, 1, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp.hold_valid", out_valid, 1);
            chk("bp.hold_a", out_a, 8'h02);
            chk("bp.hold_flags", {sat_enable, sat_sign, sat_last}, 0);
            chk("bp.hold_in", in_ready, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        expect_out("bp.o0", 8'h02, 0, 0, 0, 0);
        expect_out("bp.o1", 8'h01, 0, 0, 1, 0);

        // overlength: fourth pair forced as MSB, fifth starts a new word
        send("ol0", 8'h01, 8'h00, 0, 0);
        send("ol1", 8'h02, 8'h00, 0, 0);
        send("ol2", 8'h03, 8'h00, 0, 0);
        send("ol3", 8'h04, 8'h00, 0, 0);
        expect_out("ol.o0", 8'h01, 0, 0, 0, 1);
        expect_out("ol.o1", 8'h02, 0, 0, 0, 0);
        expect_out("ol.o2", 8'h03, 0, 0, 0, 0);
        expect_out("ol.o3", 8'h04, 0, 0, 1, 0);
        send("ol4", 8'h10, 8'h05, 0, 0);
        send("ol5", 8'h20, 8'h06, 1, 0);
        expect_out("ol.n0", 8'h15, 0, 0, 0, 0);
        expect_out("ol.n1", 8'h26, 0, 0, 1, 0);

        // reset asserted mid-EMIT discards the word
        send("rs0", 8'h11, 8'h11, 0, 0);
        send("rs1", 8'h22, 8'h22, 1, 0);
        @(negedge clk);
        chk("rs.pre_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("rs.out_valid", out_valid, 0);
        chk("rs.in_ready", in_ready, 0);
        chk("rs.out_a", out_a, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rs.rel_ready", in_ready, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rs.no_stale", out_valid, 0);
            @(posedge clk); #1;
        end

        // clean word after reset: 0x05 + 0x03
        send("post", 8'h05, 8'h03, 1, 0);
        expect_out("post.o0", 8'h08, 0, 0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
